// File: rtl/evt_buf_frmt.sv
// Event buffer and frame formatter: buffers L1A headers and sample words in
// FWFT FIFOs and emits each event as a 16-bit record over valid/ready.

module evt_buf_fifo #(
   parameter int WIDTH = 18,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      cnt,
   output logic             ovfl
);
   localparam int          DEPTH    = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_en;
   logic             wr_en;

   // A push into a full FIFO is still taken when a pop frees a slot that cycle.
   assign rd_en = pop && (cnt != '0);
   assign wr_en = push && ((cnt != FULL_CNT) || rd_en);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovfl   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (push && !wr_en) ovfl <= 1'b1;
      end
   end
endmodule

module evt_buf_frmt #(
   parameter int DEPTH_LOG2     = 11,
   parameter int HDR_DEPTH_LOG2 = 4,
   parameter int AFL_MARGIN     = 512
) (
   input  logic        CLK,
   input  logic        RST_RESYNC,
   input  logic [36:0] L1A_EVT_DATA,
   input  logic        L1A_EVT_PUSH,
   input  logic [17:0] RDATA,
   input  logic        DATA_PUSH,
   input  logic [10:0] EVT_WORDS,
   input  logic        DOUT_RD,
   output logic        EVT_BUF_AMT,
   output logic        EVT_BUF_AFL,
   output logic [15:0] DOUT,
   output logic        DOUT_VALID,
   output logic        DOUT_LAST,
   output logic [1:0]  OVFL,
   output logic [15:0] EVT_CNT
);
   localparam int                      DEPTH       = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]     AFL_LVL     = (DEPTH_LOG2+1)'(DEPTH - AFL_MARGIN);
   localparam logic [HDR_DEPTH_LOG2:0] HDR_AFL_LVL = (HDR_DEPTH_LOG2+1)'(2**HDR_DEPTH_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [1:0]                idx;
   logic [1:0]                idx_nxt;
   logic [36:0]               hdr_head;
   logic [HDR_DEPTH_LOG2:0]   hdr_cnt;
   logic [17:0]               dat_head;
   logic [DEPTH_LOG2:0]       dat_cnt;
   logic                      hdr_ovfl;
   logic                      dat_ovfl;
   logic                      hdr_avail;
   logic                      dat_avail;
   logic                      adv;
   logic                      hdr_pop;
   logic                      data_pop;
   logic                      evt_done;
   logic [15:0]               dout_nxt;
   logic                      valid_nxt;
   logic                      last_nxt;
   logic [10:0]               wc;
   logic [24:0]               hdr;
   logic [11:0]               xor_acc;
   logic                      movlp_any;
   logic                      ovrlp_any;
   logic [15:0]               h0;
   logic [15:0]               trl0;
   logic [15:0]               trl1;

   evt_buf_fifo #(.WIDTH(37), .AW(HDR_DEPTH_LOG2)) u_hdr_fifo (
      .clk(CLK), .rst(RST_RESYNC), .push(L1A_EVT_PUSH), .pop(hdr_pop),
      .din(L1A_EVT_DATA), .head(hdr_head), .cnt(hdr_cnt), .ovfl(hdr_ovfl)
   );

   evt_buf_fifo #(.WIDTH(18), .AW(DEPTH_LOG2)) u_dat_fifo (
      .clk(CLK), .rst(RST_RESYNC), .push(DATA_PUSH), .pop(data_pop),
      .din(RDATA), .head(dat_head), .cnt(dat_cnt), .ovfl(dat_ovfl)
   );

   assign OVFL      = {hdr_ovfl, dat_ovfl};
   assign hdr_avail = (hdr_cnt != '0);
   assign dat_avail = (dat_cnt != '0);
   // The output register may take a new word when empty or being transferred.
   assign adv       = !DOUT_VALID || DOUT_RD;
   assign h0        = {4'hA, hdr_head[23:12]};
   assign trl0      = {4'hE, 2'b00, movlp_any, ovrlp_any, 8'h00};
   assign trl1      = {4'hF, xor_acc};

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         state <= IDLE;
         idx   <= 2'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: if (hdr_avail) begin
            state_nxt = HDR;
            idx_nxt   = 2'd0;
         end
         HDR: if (adv) begin
            if (idx != 2'd3) begin
               idx_nxt = idx + 2'd1;
            end else if (wc != '0) begin
               state_nxt = DATA;
            end else begin
               state_nxt = TRL;
               idx_nxt   = 2'd0;
            end
         end
         DATA: if (adv && (wc == '0)) begin
            state_nxt = TRL;
            idx_nxt   = 2'd0;
         end
         TRL: if (adv) begin
            if (idx == 2'd0) begin
               idx_nxt = 2'd1;
            end else if (hdr_avail) begin
               state_nxt = HDR;
               idx_nxt   = 2'd0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // wc counts words not yet loaded, so wc==0 in DATA means the last one is on DOUT.
   always_comb begin
      dout_nxt  = DOUT;
      valid_nxt = DOUT_VALID;
      last_nxt  = DOUT_LAST;
      hdr_pop   = 1'b0;
      data_pop  = 1'b0;
      evt_done  = 1'b0;
      case (state)
         IDLE: if (hdr_avail) begin
            hdr_pop   = 1'b1;
            dout_nxt  = h0;
            valid_nxt = 1'b1;
            last_nxt  = 1'b0;
         end
         HDR: if (adv) begin
            case (idx)
               2'd0: dout_nxt = {4'hA, hdr[11:0]};
               2'd1: dout_nxt = {4'hB, hdr[23:12]};
               2'd2: dout_nxt = {4'hC, hdr[24], wc};
               default: begin
                  if (wc != '0) begin
                     if (dat_avail) begin
                        data_pop = 1'b1;
                        dout_nxt = dat_head[15:0];
                     end
                     valid_nxt = dat_avail;
                  end else begin
                     dout_nxt = trl0;
                  end
               end
            endcase
         end
         DATA: if (adv) begin
            if (wc == '0) begin
               dout_nxt  = trl0;
               valid_nxt = 1'b1;
            end else begin
               if (dat_avail) begin
                  data_pop = 1'b1;
                  dout_nxt = dat_head[15:0];
               end
               valid_nxt = dat_avail;
            end
         end
         TRL: if (adv) begin
            if (idx == 2'd0) begin
               dout_nxt = trl1;
               last_nxt = 1'b1;
            end else begin
               evt_done = 1'b1;
               last_nxt = 1'b0;
               if (hdr_avail) begin
                  hdr_pop  = 1'b1;
                  dout_nxt = h0;
               end
               valid_nxt = hdr_avail;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         DOUT        <= 16'h0000;
         DOUT_VALID  <= 1'b0;
         DOUT_LAST   <= 1'b0;
         EVT_CNT     <= 16'h0000;
         EVT_BUF_AMT <= 1'b1;
         EVT_BUF_AFL <= 1'b0;
         wc          <= '0;
      end else begin
         DOUT        <= dout_nxt;
         DOUT_VALID  <= valid_nxt;
         DOUT_LAST   <= last_nxt;
         if (evt_done) EVT_CNT <= EVT_CNT + 16'd1;
         EVT_BUF_AMT <= !hdr_avail && !dat_avail && (state == IDLE);
         EVT_BUF_AFL <= (dat_cnt >= AFL_LVL) || (hdr_cnt >= HDR_AFL_LVL);
         if (hdr_pop)       wc <= EVT_WORDS;
         else if (data_pop) wc <= wc - 11'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (hdr_pop) begin
         hdr       <= {hdr_head[36:24], hdr_head[11:0]};
         xor_acc   <= '0;
         movlp_any <= 1'b0;
         ovrlp_any <= 1'b0;
      end else if (data_pop) begin
         xor_acc   <= xor_acc ^ dat_head[11:0];
         movlp_any <= movlp_any | dat_head[17];
         ovrlp_any <= ovrlp_any | dat_head[16];
      end
   end
endmodule

// File: tb/tb_evt_buf_frmt.sv
// Bench for evt_buf_frmt: frame words are scored against an expected queue
// filled when stimulus is driven; flags and counters are checked directly.

module tb_evt_buf_frmt;
   localparam int DEPTH_LOG2     = 4;
   localparam int HDR_DEPTH_LOG2 = 4;
   localparam int AFL_MARGIN     = 4;

   logic        CLK = 1'b0;
   logic        RST_RESYNC;
   logic [36:0] L1A_EVT_DATA;
   logic        L1A_EVT_PUSH;
   logic [17:0] RDATA;
   logic        DATA_PUSH;
   logic [10:0] EVT_WORDS;
   logic        DOUT_RD;
   logic        EVT_BUF_AMT;
   logic        EVT_BUF_AFL;
   logic [15:0] DOUT;
   logic        DOUT_VALID;
   logic        DOUT_LAST;
   logic [1:0]  OVFL;
   logic [15:0] EVT_CNT;

   evt_buf_frmt #(
      .DEPTH_LOG2(DEPTH_LOG2), .HDR_DEPTH_LOG2(HDR_DEPTH_LOG2), .AFL_MARGIN(AFL_MARGIN)
   ) dut (
      .CLK(CLK), .RST_RESYNC(RST_RESYNC), .L1A_EVT_DATA(L1A_EVT_DATA),
      .L1A_EVT_PUSH(L1A_EVT_PUSH), .RDATA(RDATA), .DATA_PUSH(DATA_PUSH),
      .EVT_WORDS(EVT_WORDS), .DOUT_RD(DOUT_RD), .EVT_BUF_AMT(EVT_BUF_AMT),
      .EVT_BUF_AFL(EVT_BUF_AFL), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
      .DOUT_LAST(DOUT_LAST), .OVFL(OVFL), .EVT_CNT(EVT_CNT)
   );

   always #5 CLK = ~CLK;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [16:0] exp_q[$];
   logic [17:0] evt_data[$];
   logic [15:0] exp_evt = 16'd0;
   bit          mon_en = 1'b0;
   bit          rd_toggle = 1'b0;
   logic        hold_p = 1'b0;
   logic [16:0] hold_w = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Words are scored at the falling edge preceding their transfer edge.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (hold_p) begin
            chk("hold_valid", 32'(DOUT_VALID), 32'd1);
            chk("hold_word", 32'({DOUT_LAST, DOUT}), 32'(hold_w));
         end
         if (DOUT_VALID && DOUT_RD) begin
            if (exp_q.size() == 0) chk("extra_word", 32'({DOUT_LAST, DOUT}), 32'hDEAD_BEEF);
            else chk("frame_word", 32'({DOUT_LAST, DOUT}), 32'(exp_q.pop_front()));
         end
         hold_p <= DOUT_VALID && !DOUT_RD;
         hold_w <= {DOUT_LAST, DOUT};
      end else begin
         hold_p <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rd_toggle) DOUT_RD = ~DOUT_RD;
   endtask

   task automatic push_hdr(input logic phs, input logic [11:0] mtch, input logic [23:0] num,
                           input logic [10:0] nw);
      L1A_EVT_DATA = {phs, mtch, num};
      EVT_WORDS    = nw;
      L1A_EVT_PUSH = 1'b1;
      tick();
      L1A_EVT_PUSH = 1'b0;
   endtask

   task automatic push_data(input logic [17:0] w);
      RDATA     = w;
      DATA_PUSH = 1'b1;
      tick();
      DATA_PUSH = 1'b0;
   endtask

   // Reference frame built from the header fields and the queued sample words.
   task automatic exp_frame(input logic phs, input logic [11:0] mtch, input logic [23:0] num,
                            input logic [10:0] nw);
      logic [11:0] x;
      logic        mv;
      logic        ov;
      logic [17:0] w;
      x  = 12'h000;
      mv = 1'b0;
      ov = 1'b0;
      exp_q.push_back({1'b0, 4'hA, num[23:12]});
      exp_q.push_back({1'b0, 4'hA, num[11:0]});
      exp_q.push_back({1'b0, 4'hB, mtch});
      exp_q.push_back({1'b0, 4'hC, phs, nw});
      for (int i = 0; i < int'(nw); i++) begin
         w = evt_data.pop_front();
         exp_q.push_back({1'b0, w[15:0]});
         x  = x ^ w[11:0];
         mv = mv | w[17];
         ov = ov | w[16];
      end
      exp_q.push_back({1'b0, 4'hE, 2'b00, mv, ov, 8'h00});
      exp_q.push_back({1'b1, 4'hF, x});
      exp_evt = exp_evt + 16'd1;
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [17:0] w;
      logic        found;
      RST_RESYNC   = 1'b1;
      L1A_EVT_DATA = '0;
      L1A_EVT_PUSH = 1'b0;
      RDATA        = '0;
      DATA_PUSH    = 1'b0;
      EVT_WORDS    = '0;
      DOUT_RD      = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_amt", 32'(EVT_BUF_AMT), 32'd1);
      chk("rst_afl", 32'(EVT_BUF_AFL), 32'd0);
      chk("rst_dout", 32'(DOUT), 32'd0);
      chk("rst_valid", 32'(DOUT_VALID), 32'd0);
      chk("rst_last", 32'(DOUT_LAST), 32'd0);
      chk("rst_ovfl", 32'(OVFL), 32'd0);
      chk("rst_evt_cnt", 32'(EVT_CNT), 32'd0);
      RST_RESYNC = 1'b0;
      tick();
      mon_en = 1'b1;

      // Basic frame against hand-computed words.
      exp_q.push_back(17'h0AABC); exp_q.push_back(17'h0ADEF); exp_q.push_back(17'h0B123);
      exp_q.push_back(17'h0C803); exp_q.push_back(17'h00111); exp_q.push_back(17'h00222);
      exp_q.push_back(17'h00444); exp_q.push_back(17'h0E000); exp_q.push_back(17'h1F777);
      exp_evt = 16'd1;
      push_hdr(1'b1, 12'h123, 24'hABCDEF, 11'd3);
      push_data(18'h00111);
      push_data(18'h00222);
      push_data(18'h00444);
      wait_drain(50);
      chk("basic_evt_cnt", 32'(EVT_CNT), 32'(exp_evt));
      chk("basic_amt", 32'(EVT_BUF_AMT), 32'd1);

      // Same event under alternating backpressure.
      rd_toggle = 1'b1;
      evt_data.push_back(18'h00111); evt_data.push_back(18'h00222); evt_data.push_back(18'h00444);
      exp_frame(1'b1, 12'h123, 24'hABCDEF, 11'd3);
      push_hdr(1'b1, 12'h123, 24'hABCDEF, 11'd3);
      push_data(18'h00111);
      push_data(18'h00222);
      push_data(18'h00444);
      wait_drain(80);
      rd_toggle = 1'b0;
      DOUT_RD   = 1'b1;
      chk("bp_evt_cnt", 32'(EVT_CNT), 32'(exp_evt));

      // Data starvation: header first, samples 20 cycles later.
      evt_data.push_back(18'h0A5A5); evt_data.push_back(18'h0C3C3);
      exp_frame(1'b0, 12'h456, 24'h123456, 11'd2);
      push_hdr(1'b0, 12'h456, 24'h123456, 11'd2);
      repeat (20) tick();
      chk("starve_valid", 32'(DOUT_VALID), 32'd0);
      chk("starve_pending", 32'(exp_q.size()), 32'd4);
      push_data(18'h0A5A5);
      push_data(18'h0C3C3);
      wait_drain(50);
      chk("starve_evt_cnt", 32'(EVT_CNT), 32'(exp_evt));

      // Overlap flags, with the sample arriving before its header.
      evt_data.push_back({1'b1, 1'b1, 4'h5, 12'h0F0});
      push_data({1'b1, 1'b1, 4'h5, 12'h0F0});
      exp_frame(1'b0, 12'h001, 24'h000777, 11'd1);
      push_hdr(1'b0, 12'h001, 24'h000777, 11'd1);
      wait_drain(50);

      // Empty event.
      exp_frame(1'b0, 12'h7FF, 24'h000001, 11'd0);
      push_hdr(1'b0, 12'h7FF, 24'h000001, 11'd0);
      wait_drain(50);
      chk("empty_evt_cnt", 32'(EVT_CNT), 32'(exp_evt));
      chk("empty_amt", 32'(EVT_BUF_AMT), 32'd1);

      // Data FIFO almost-full and overflow with no header present.
      DOUT_RD = 1'b0;
      for (int i = 0; i < 17; i++) begin
         w = {2'b00, i[3:0], 12'h100 + 12'(i)};
         if (i < 16) evt_data.push_back(w);
         push_data(w);
         if (i == 10) begin tick(); chk("afl_below", 32'(EVT_BUF_AFL), 32'd0); end
         if (i == 11) begin tick(); chk("afl_at", 32'(EVT_BUF_AFL), 32'd1); end
         if (i == 15) chk("ovfl_at_full", 32'(OVFL), 32'd0);
      end
      chk("ovfl_data", 32'(OVFL), 32'd1);
      chk("amt_busy", 32'(EVT_BUF_AMT), 32'd0);
      DOUT_RD = 1'b1;
      exp_frame(1'b1, 12'hFED, 24'h00BEEF, 11'd16);
      push_hdr(1'b1, 12'hFED, 24'h00BEEF, 11'd16);
      wait_drain(100);
      chk("ovfl_evt_cnt", 32'(EVT_CNT), 32'(exp_evt));
      chk("ovfl_drained_amt", 32'(EVT_BUF_AMT), 32'd1);
      chk("ovfl_sticky", 32'(OVFL), 32'd1);

      // Reset asserted while a data word is on DOUT.
      mon_en = 1'b0;
      push_hdr(1'b0, 12'h321, 24'h654321, 11'd4);
      push_data({2'b00, 4'h3, 12'h5A5});
      push_data({2'b00, 4'h0, 12'hBBB});
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (DOUT_VALID && DOUT == 16'h35A5) found = 1'b1;
      end
      chk("midframe_reached", 32'(found), 32'd1);
      DOUT_RD    = 1'b0;
      RST_RESYNC = 1'b1;
      #1;
      chk("midrst_valid", 32'(DOUT_VALID), 32'd0);
      chk("midrst_amt", 32'(EVT_BUF_AMT), 32'd1);
      chk("midrst_ovfl", 32'(OVFL), 32'd0);
      chk("midrst_evt_cnt", 32'(EVT_CNT), 32'd0);
      chk("midrst_last", 32'(DOUT_LAST), 32'd0);
      tick();
      tick();
      RST_RESYNC = 1'b0;
      tick();
      exp_q.delete();
      evt_data.delete();
      exp_evt = 16'd0;
      mon_en  = 1'b1;
      DOUT_RD = 1'b1;
      evt_data.push_back(18'h01234); evt_data.push_back(18'h05678);
      exp_frame(1'b1, 12'h0AA, 24'hC0FFEE, 11'd2);
      push_data(18'h01234);
      push_data(18'h05678);
      push_hdr(1'b1, 12'h0AA, 24'hC0FFEE, 11'd2);
      wait_drain(50);
      chk("post_rst_evt_cnt", 32'(EVT_CNT), 32'd1);
      chk("post_rst_amt", 32'(EVT_BUF_AMT), 32'd1);

      // Header FIFO overflow: the first header is taken by the FSM, 16 more fill it.
      DOUT_RD = 1'b0;
      for (int i = 0; i < 18; i++) begin
         push_hdr(1'b0, 12'(i), 24'(i), 11'd0);
         if (i == 16) chk("hdr_ovfl_at_full", 32'(OVFL), 32'd0);
      end
      tick();
      chk("ovfl_hdr", 32'(OVFL), 32'd2);
      chk("hdr_afl", 32'(EVT_BUF_AFL), 32'd1);
      chk("hdr_h0_held", 32'({DOUT_VALID, DOUT}), 32'h1A000);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
